// File: rtl/chacha_param_loader.sv
// chacha_param_loader: assembles key/nonce/counter word by word from a stream or the TRNG
// and hands the set to the ChaCha20 core, with a reuse mode that only bumps the counter.
module chacha_param_loader #(
   parameter int CHUNK_W     = 32,
   parameter int KEY_WORDS   = 8,
   parameter int NONCE_WORDS = 3,
   parameter int CTR_WORDS   = 1,
   parameter int IDX_W       = 5
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic                          reload,
   input  logic                          abort,
   input  logic [2:0]                    src_stream,
   output logic                          busy,
   output logic                          done,
   output logic                          type_err,
   input  logic                          chunk_valid,
   input  logic [1:0]                    chunk_type,
   input  logic [CHUNK_W-1:0]            chunk_data,
   output logic                          chunk_ready,
   output logic [IDX_W-1:0]              chunk_index,
   input  logic                          trng_valid,
   input  logic [CHUNK_W-1:0]            trng_data,
   output logic                          trng_req,
   output logic [KEY_WORDS*CHUNK_W-1:0]  key,
   output logic [NONCE_WORDS*CHUNK_W-1:0] nonce,
   output logic [CTR_WORDS*CHUNK_W-1:0]  counter,
   output logic                          out_valid,
   input  logic                          out_ready
);
   localparam int CTR_W = CTR_WORDS * CHUNK_W;
   localparam logic [IDX_W-1:0] KEY_LAST   = IDX_W'(KEY_WORDS - 1);
   localparam logic [IDX_W-1:0] NONCE_LAST = IDX_W'(NONCE_WORDS - 1);
   localparam logic [IDX_W-1:0] CTR_LAST   = IDX_W'(CTR_WORDS - 1);

   typedef enum logic [2:0] {IDLE, LD_KEY, LD_NONCE, LD_CTR, OUT, FIN} state_t;

   state_t                         state_q;
   logic [IDX_W-1:0]               idx_q;
   logic [2:0]                     src_q;
   logic                           loaded_q, busy_q, done_q, type_err_q, out_valid_q;
   logic [KEY_WORDS*CHUNK_W-1:0]   key_q;
   logic [NONCE_WORDS*CHUNK_W-1:0] nonce_q;
   logic [CTR_W-1:0]               ctr_q;

   logic [1:0]         fld;
   logic               in_fld, stream, acc, type_ok, last;
   logic [CHUNK_W-1:0] wdata;

   always_comb begin
      fld     = state_q == LD_NONCE ? 2'd1 : state_q == LD_CTR ? 2'd2 : 2'd0;
      in_fld  = state_q == LD_KEY || state_q == LD_NONCE || state_q == LD_CTR;
      stream  = src_q[fld];
      acc     = in_fld && (stream ? chunk_valid : trng_valid);
      wdata   = stream ? chunk_data : trng_data;
      type_ok = !stream || chunk_type == fld;
      last    = idx_q == (state_q == LD_NONCE ? NONCE_LAST : state_q == LD_CTR ? CTR_LAST : KEY_LAST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         src_q       <= '0;
         loaded_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         type_err_q  <= 1'b0;
         out_valid_q <= 1'b0;
         key_q       <= '0;
         nonce_q     <= '0;
         ctr_q       <= '0;
      end else begin
         done_q     <= 1'b0;
         type_err_q <= 1'b0;
         // abort outranks everything outside IDLE, even a same-cycle out handshake
         if (abort && state_q != IDLE) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            loaded_q    <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            key_q       <= '0;
            nonce_q     <= '0;
            ctr_q       <= '0;
         end else begin
            case (state_q)
               IDLE: if (start && !abort) begin
                  src_q  <= src_stream;
                  busy_q <= 1'b1;
                  idx_q  <= '0;
                  if (reload || !loaded_q) state_q <= LD_KEY;
                  else begin
                     ctr_q       <= ctr_q + CTR_W'(1);
                     out_valid_q <= 1'b1;
                     state_q     <= OUT;
                  end
               end
               LD_KEY, LD_NONCE, LD_CTR: if (acc) begin
                  if (!type_ok) type_err_q <= 1'b1;
                  else begin
                     if (state_q == LD_KEY) key_q[int'(idx_q)*CHUNK_W +: CHUNK_W] <= wdata;
                     if (state_q == LD_NONCE) nonce_q[int'(idx_q)*CHUNK_W +: CHUNK_W] <= wdata;
                     if (state_q == LD_CTR) ctr_q[int'(idx_q)*CHUNK_W +: CHUNK_W] <= wdata;
                     if (last) begin
                        idx_q       <= '0;
                        state_q     <= state_q == LD_KEY ? LD_NONCE : state_q == LD_NONCE ? LD_CTR : OUT;
                        out_valid_q <= state_q == LD_CTR;
                     end else idx_q <= idx_q + IDX_W'(1);
                  end
               end
               OUT: if (out_ready) begin
                  out_valid_q <= 1'b0;
                  loaded_q    <= 1'b1;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
                  state_q     <= FIN;
               end
               FIN: state_q <= IDLE;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign type_err    = type_err_q;
   assign chunk_ready = in_fld && stream;
   assign trng_req    = in_fld && !stream;
   assign chunk_index = idx_q;
   assign key         = key_q;
   assign nonce       = nonce_q;
   assign counter     = ctr_q;
   assign out_valid   = out_valid_q;
endmodule

// File: tb/tb_chacha_param_loader.sv
// tb_chacha_param_loader: directed vectors for chacha_param_loader; streamed word tables
// plus hand-written sequences for reuse, TRNG, back-pressure, abort and async reset.
module tb_chacha_param_loader;
   logic clk = 0, rst_n = 0;
   logic start = 0, reload = 0, abort = 0;
   logic [2:0] src_stream = 0;
   logic busy, done, type_err, chunk_ready, trng_req, out_valid;
   logic chunk_valid = 0, trng_valid = 0, out_ready = 0;
   logic [1:0] chunk_type = 0;
   logic [31:0] chunk_data = 0, trng_data = 0;
   logic [4:0] chunk_index;
   logic [255:0] key;
   logic [95:0] nonce;
   logic [31:0] counter;

   chacha_param_loader dut (
      .clk(clk), .rst_n(rst_n), .start(start), .reload(reload), .abort(abort),
      .src_stream(src_stream), .busy(busy), .done(done), .type_err(type_err),
      .chunk_valid(chunk_valid), .chunk_type(chunk_type), .chunk_data(chunk_data),
      .chunk_ready(chunk_ready), .chunk_index(chunk_index), .trng_valid(trng_valid),
      .trng_data(trng_data), .trng_req(trng_req), .key(key), .nonce(nonce),
      .counter(counter), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  typ;
      logic [31:0] data;
      logic [4:0]  idx;
      logic        err;
   } vec_t;

   vec_t tv[25];
   int total = 0, bad = 0;
   logic [255:0] key_a, key_b, key_t;
   logic [95:0]  nonce_a, nonce_b, nonce_t;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] t, input logic [31:0] d, input logic [4:0] ei, input logic ee);
      chk("chunk_index", chunk_index, ei);
      chunk_valid = 1; chunk_type = t; chunk_data = d;
      tick;
      chunk_valid = 0;
      chk("type_err", type_err, ee);
   endtask

   task automatic go(input logic rl, input logic [2:0] src);
      start = 1; reload = rl; src_stream = src;
      tick;
      start = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      for (int k = 0; k < 8; k++) tv[k] = '{2'd0, 32'h11111111 + 32'(k), 5'(k), 1'b0};
      for (int k = 0; k < 3; k++) tv[8+k] = '{2'd1, 32'h11111119 + 32'(k), 5'(k), 1'b0};
      tv[11] = '{2'd2, 32'h1111111C, 5'd0, 1'b0};
      for (int k = 0; k < 3; k++) tv[12+k] = '{2'd0, 32'hA0000000 + 32'(k), 5'(k), 1'b0};
      tv[15] = '{2'd1, 32'hDEADBEEF, 5'd3, 1'b1};
      for (int k = 3; k < 8; k++) tv[13+k] = '{2'd0, 32'hA0000000 + 32'(k), 5'(k), 1'b0};
      for (int k = 0; k < 3; k++) tv[21+k] = '{2'd1, 32'hB0000000 + 32'(k), 5'(k), 1'b0};
      tv[24] = '{2'd2, 32'hFFFFFFFF, 5'd0, 1'b0};
      for (int k = 0; k < 8; k++) begin
         key_a[k*32 +: 32] = 32'h11111111 + 32'(k);
         key_b[k*32 +: 32] = 32'hA0000000 + 32'(k);
         key_t[k*32 +: 32] = 32'hC0000000 + 32'(k);
      end
      for (int k = 0; k < 3; k++) begin
         nonce_a[k*32 +: 32] = 32'h11111119 + 32'(k);
         nonce_b[k*32 +: 32] = 32'hB0000000 + 32'(k);
         nonce_t[k*32 +: 32] = 32'hD0000000 + 32'(k);
      end

      // reset values
      tick; tick;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_key", key, 0);
      chk("rst_counter", counter, 0);
      chk("rst_chunk_ready", chunk_ready, 0);
      chk("rst_trng_req", trng_req, 0);
      rst_n = 1;
      tick;

      // full streamed load
      out_ready = 1;
      go(1, 3'b111);
      chk("ld_busy", busy, 1);
      chk("ld_chunk_ready", chunk_ready, 1);
      chk("ld_trng_req", trng_req, 0);
      for (int i = 0; i < 12; i++) send(tv[i].typ, tv[i].data, tv[i].idx, tv[i].err);
      chk("ld_out_valid", out_valid, 1);
      chk("ld_key", key, key_a);
      chk("ld_nonce", nonce, nonce_a);
      chk("ld_counter", counter, 32'h1111111C);
      tick;
      chk("ld_done", done, 1);
      chk("ld_busy_fin", busy, 0);
      chk("ld_out_valid_fin", out_valid, 0);
      tick;
      chk("ld_done_pulse", done, 0);

      // reuse: counter increments, key/nonce kept
      go(0, 3'b111);
      chk("reuse_out_valid", out_valid, 1);
      chk("reuse_counter", counter, 32'h1111111D);
      chk("reuse_key", key, key_a);
      chk("reuse_nonce", nonce, nonce_a);
      tick;
      chk("reuse_done", done, 1);
      tick;

      // load with a type mismatch at key index 3, counter all-ones
      go(1, 3'b111);
      for (int i = 12; i < 25; i++) send(tv[i].typ, tv[i].data, tv[i].idx, tv[i].err);
      chk("mm_out_valid", out_valid, 1);
      chk("mm_key", key, key_b);
      chk("mm_key_w3", key[127:96], 32'hA0000003);
      chk("mm_nonce", nonce, nonce_b);
      chk("mm_counter", counter, 32'hFFFFFFFF);
      tick; tick;
      go(0, 3'b111);
      chk("wrap_counter", counter, 32'h00000000);
      chk("wrap_key", key, key_b);
      tick;
      chk("wrap_done", done, 1);
      tick;

      // TRNG key, streamed nonce/counter; stray stream words ignored in LD_KEY
      go(1, 3'b110);
      chunk_valid = 1; chunk_type = 0; chunk_data = 32'hBAD0BAD0;
      n = 0;
      for (int c = 0; c < 40 && n < 8; c++) begin
         chk("trng_req_key", trng_req, 1);
         chk("trng_chunk_ready", chunk_ready, 0);
         trng_valid = (c % 3 == 2);
         trng_data = 32'hC0000000 + 32'(n);
         if (trng_valid) n++;
         tick;
      end
      trng_valid = 0; chunk_valid = 0;
      chk("trng_count", 256'(n), 8);
      chk("trng_req_nonce", trng_req, 0);
      chk("trng_chunk_ready_nonce", chunk_ready, 1);
      for (int j = 0; j < 3; j++) send(2'd1, 32'hD0000000 + 32'(j), 5'(j), 1'b0);
      send(2'd2, 32'h5, 5'd0, 1'b0);
      chk("trng_out_valid", out_valid, 1);
      chk("trng_key", key, key_t);
      chk("trng_nonce", nonce, nonce_t);
      tick;
      chk("trng_done", done, 1);
      tick;

      // back-pressure in OUT
      out_ready = 0;
      go(0, 3'b111);
      for (int i = 0; i < 10; i++) begin
         chk("bp_out_valid", out_valid, 1);
         chk("bp_counter", counter, 32'h6);
         chk("bp_key", key, key_t);
         chk("bp_done", done, 0);
         tick;
      end
      out_ready = 1;
      tick;
      chk("bp_done_after", done, 1);
      chk("bp_out_valid_after", out_valid, 0);
      tick;

      // abort at key index 5
      go(1, 3'b111);
      for (int w = 0; w < 5; w++) send(2'd0, 32'hE0000000 + 32'(w), 5'(w), 1'b0);
      chk("ab_index", chunk_index, 5);
      chunk_valid = 1; chunk_type = 0; chunk_data = 32'h12345678; abort = 1;
      tick;
      abort = 0; chunk_valid = 0;
      chk("ab_busy", busy, 0);
      chk("ab_key", key, 0);
      chk("ab_nonce", nonce, 0);
      chk("ab_counter", counter, 0);
      chk("ab_index0", chunk_index, 0);
      chk("ab_chunk_ready", chunk_ready, 0);
      chk("ab_done", done, 0);
      tick;
      chk("ab_done_late", done, 0);
      go(0, 3'b111);
      chk("ab_full_load", chunk_ready, 1);
      chk("ab_no_out_valid", out_valid, 0);
      chk("ab_busy2", busy, 1);
      abort = 1; start = 1;
      tick; tick;
      abort = 0; start = 0;
      chk("ab_idle_busy", busy, 0);
      chk("ab_idle_ready", chunk_ready, 0);

      // async reset mid LD_NONCE
      go(1, 3'b111);
      for (int i = 0; i < 9; i++) send(tv[i].typ, tv[i].data, tv[i].idx, tv[i].err);
      chk("ar_index", chunk_index, 1);
      #2 rst_n = 0;
      #1;
      chk("ar_key", key, 0);
      chk("ar_busy", busy, 0);
      chk("ar_chunk_ready", chunk_ready, 0);
      chk("ar_index0", chunk_index, 0);
      chk("ar_out_valid", out_valid, 0);
      tick;
      rst_n = 1;
      tick;
      go(1, 3'b111);
      for (int i = 0; i < 12; i++) send(tv[i].typ, tv[i].data, tv[i].idx, tv[i].err);
      chk("ar2_out_valid", out_valid, 1);
      chk("ar2_key", key, key_a);
      chk("ar2_counter", counter, 32'h1111111C);
      tick;
      chk("ar2_done", done, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
